// File: rtl/serial_pkg.sv
// Shared serial-link definitions used by the transmitter and the future receiver.
// Contents:
//   serial_state_t      frame FSM states
//   SERIAL_*_LEVEL      line levels for idle, start and stop bits
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } serial_state_t;

   localparam logic SERIAL_IDLE_LEVEL  = 1'b1;
   localparam logic SERIAL_START_LEVEL = 1'b0;
   localparam logic SERIAL_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_tx_shifter.sv
// Data shift register for serial_tx.
// Loads a word on load, shifts right (zero fill) on shift; load has priority.
// Optional macro SERIAL_TX_PARITY_EN adds a parity register captured on load.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   load        capture d into the shift register
//   shift       shift the register right by one
//   d           word to load
//   bit0        current LSB of the shift register
//   par         (SERIAL_TX_PARITY_EN only) even parity of the last loaded word
module serial_tx_shifter #(
   parameter int unsigned NBITS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [NBITS-1:0] d,
`ifdef SERIAL_TX_PARITY_EN
   output logic             par,
`endif
   output logic             bit0
);

   logic [NBITS-1:0] sh;

   always_ff @(posedge clk) begin
      if (reset) begin
         sh <= '0;
      end else if (load) begin
         sh <= d;
      end else if (shift) begin
         sh <= sh >> 1;
      end
   end

   assign bit0 = sh[0];

`ifdef SERIAL_TX_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         par <= 1'b0;
      end else if (load) begin
         par <= ^d;
      end
   end
`endif

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, NBITS data bits LSB-first,
// optional even parity bit, stop bit. Line is registered and idles high.
// Optional macro SERIAL_TX_PARITY_EN inserts the parity bit after the data.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   in_val      producer has a valid word on in_msg
//   in_rdy      transmitter accepts a word this cycle (IDLE or STOP, not in reset)
//   in_msg      word to transmit, latched only on transfer
//   out         serial line (flop output)
//   busy        frame in progress
module serial_tx
   import serial_pkg::*;
#(
   parameter int unsigned NBITS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [NBITS-1:0] in_msg,
   output logic             out,
   output logic             busy
);

   localparam int unsigned   CW   = $clog2(NBITS) + 1;
   localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

   serial_state_t state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          out_d;
   logic          xfer;
   logic          shift_en;
   logic          sh_bit0;
`ifdef SERIAL_TX_PARITY_EN
   logic          sh_par;
`endif

   assign in_rdy = ((state == IDLE) || (state == STOP)) && !reset;
   assign xfer   = in_val && in_rdy;
   assign busy   = (state != IDLE);

   serial_tx_shifter #(
      .NBITS(NBITS)
   ) u_shifter (
      .clk   (clk),
      .reset (reset),
      .load  (xfer),
      .shift (shift_en),
      .d     (in_msg),
`ifdef SERIAL_TX_PARITY_EN
      .par   (sh_par),
`endif
      .bit0  (sh_bit0)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         out   <= SERIAL_IDLE_LEVEL;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         out   <= out_d;
      end
   end

   // out is registered from the next state, so the line level is decided one
   // edge ahead. The shifter advances on every edge that enters or stays in
   // DATA, which presents the next data bit at its bit0 just in time.
   always_comb begin
      state_d  = state;
      cnt_d    = '0;
      out_d    = SERIAL_IDLE_LEVEL;
      shift_en = 1'b0;

      unique case (state)
         IDLE:  if (xfer) state_d = START;
         START: state_d = DATA;
         DATA: begin
            if (cnt == LAST) begin
`ifdef SERIAL_TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: state_d = STOP;
`endif
         STOP:    state_d = xfer ? START : IDLE;
         default: state_d = IDLE;
      endcase

      shift_en = (state_d == DATA);

      unique case (state_d)
         START: out_d = SERIAL_START_LEVEL;
         DATA:  out_d = sh_bit0;
`ifdef SERIAL_TX_PARITY_EN
         PARITY: out_d = sh_par;
`endif
         STOP:    out_d = SERIAL_STOP_LEVEL;
         default: out_d = SERIAL_IDLE_LEVEL;
      endcase
   end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-to-serial frame transmitter. Accepts an NBITS-wide word over a val/rdy handshake and drives it onto a single-bit serial line as start bit, data LSB-first, optional parity, and stop bit. It is the driving end of the one-bit registered line that downstream logic samples with a plain D flip-flop. Sits between a parallel message producer and any single-wire serial link in the design.

## Interface

- NBITS, 8, data bits per frame (legal range 1..32)
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- in_val  input  1  producer has a valid word on in_msg
- in_rdy  output  1  transmitter can accept a word this cycle
- in_msg  input  NBITS  word to transmit
- out  output  1  serial line, registered, idle-high
- busy  output  1  frame in progress (any state other than IDLE)

## Operation

- The FSM has four states: IDLE, START, DATA, STOP (plus PARITY when configured).
- Reset values: state=IDLE, out=1, busy=0, bit counter=0, shift register=0. While reset=1, in_rdy=0.
- in_rdy = (state==IDLE || state==STOP) && !reset. It is a function of state only and never depends on in_val.
- Transfer occurs on a posedge where in_val && in_rdy. On transfer, in_msg is latched into the shift register and the next state is START. in_msg is ignored at all other times.
- START: drives out=0 for one cycle, then goes to DATA with counter=0.
- DATA: drives out=shift[0]. The register shifts right each cycle and the counter increments. After NBITS cycles it goes to STOP (or PARITY).
- STOP: drives out=1 for one cycle. With a transfer it goes to START; without one it goes to IDLE.
- IDLE: drives out=1.
- The counter width is $clog2(NBITS)+1. The counter compares against NBITS-1, with no wrap inside a frame.
- in_val held high with changing in_msg while not ready has no effect.
- Reset asserted mid-frame aborts the frame immediately. On the next cycle out=1, state=IDLE, and no partial stop bit is emitted.

## Timing

- Transfer at edge T: start bit is on out in the cycle after T. Data bit i is on out in cycle T+2+i. The stop bit is in cycle T+2+NBITS.
- Frame length is NBITS+2 cycles (NBITS+3 with parity).
- Back-to-back: a transfer during STOP puts the next start bit in the immediately following cycle, with no idle gap. Sustained throughput is one word per NBITS+2 cycles.
- out is driven directly from a flop, with no combinational path from inputs to out.
- busy is high from cycle T+1 through the stop-bit cycle. It stays high across back-to-back frames.

## Configuration

- Macro: SERIAL_TX_PARITY_EN.
- Defined: the PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of all NBITS data bits), computed at transfer time and held in a 1-bit register. The stop bit moves to T+3+NBITS, and in_rdy asserts in STOP only.
- Undefined: there is no PARITY state and no parity register, and the frame is NBITS+2 cycles.

## Structure

- Shared package serial_pkg holds the following, so the future receiver uses identical definitions:
  - state enum serial_state_t (IDLE, START, DATA, PARITY, STOP)
  - constants SERIAL_IDLE_LEVEL=1, SERIAL_START_LEVEL=0, SERIAL_STOP_LEVEL=1
- One sub-module, serial_tx_shifter: an NBITS shift register with load and shift enables, exposing the bit-0 output and the parity of the loaded value.
- The FSM and counter stay in serial_tx.

## Test plan

- Reset for 2 cycles, then idle 5 cycles: out=1, busy=0, in_rdy=1 every cycle after reset deasserts.
- NBITS=8, in_msg=8'hA5 transferred at cycle T:
  - out is 0 in cycle T+1.
  - out is 1,0,1,0,0,1,0,1 in cycles T+2..T+9.
  - out is 1 in cycle T+10.
  - in_rdy=1 only in T+10 and after.
- Back-to-back 8'h00 then 8'hFF, in_val held high: second start bit immediately follows the first stop bit. Total of 20 cycles with busy=1 and no idle cycle between frames.
- in_val=1 with in_msg changing every cycle during a frame: the serialized bits match only the word latched at transfer.
- Reset asserted at the 4th data bit of 8'h3C: next cycle out=1, busy=0, and in_rdy=0 during reset. A new transfer after reset sends a complete, correct frame.
- With SERIAL_TX_PARITY_EN, 8'h07: parity bit 1 in cycle T+10, stop bit in T+11. 8'h03 gives parity 0.
